nco_multi_clk: RTL and testbench

//  Multi-channel numerically controlled oscillator (NCO) clock/tick generator. It is the successor to the

---
 rtl/nco_multi_clk.sv | 119 +++++++++++
 tb/tb_nco_multi_clk.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_multi_clk.sv
// Multi-channel NCO tick/clock generator.
// Each channel has a phase accumulator, an active step and a pending step.
// A written step is held as pending and becomes active only at an accumulator
// wrap, when the channel is disabled, or on a sync pulse.
// Optional feature macro: NCO_SYNC_EN adds the sync_in port, which phase-aligns all channels.
module nco_multi_clk #(
  parameter int unsigned     CH           = 2,
  parameter int unsigned     AW           = 1,
  parameter int unsigned     ACC_W        = 32,
  parameter longint unsigned DEFAULT_STEP = 64'd158329674
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [CH-1:0]    ch_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ACC_W-1:0] wr_data,
  output logic [CH-1:0]    step_pending,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick
`ifdef NCO_SYNC_EN
  ,
  input  logic             sync_in
`endif
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] acc_q  [CH];
  logic [ACC_W-1:0] acc_d  [CH];
  logic [ACC_W-1:0] step_q [CH];
  logic [ACC_W-1:0] step_d [CH];
  logic [ACC_W-1:0] pend_q [CH];
  logic [ACC_W-1:0] pend_d [CH];
  logic [CH-1:0]    pend_valid_q, pend_valid_d;
  logic [CH-1:0]    clk_out_q, clk_out_d;
  logic [CH-1:0]    tick_q, tick_d;
  logic             sync_c;

`ifdef NCO_SYNC_EN
  assign sync_c = sync_in;
`else
  assign sync_c = 1'b0;
`endif

  assign step_pending = pend_valid_q;
  assign clk_out      = clk_out_q;
  assign tick         = tick_q;

  // Next-state: accumulate, wrap detection, pending-step apply and write capture per channel
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic             wr_hit;
    logic             apply;
    acc_d        = acc_q;
    step_d       = step_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    clk_out_d    = clk_out_q;
    tick_d       = tick_q;
    sum          = '0;
    wr_hit       = 1'b0;
    apply        = 1'b0;
    for (int i = 0; i < int'(CH); i++) begin
      sum    = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
      wr_hit = wr_en && (wr_addr == AW'(i));
      if (!ch_en[i]) begin
        // disabled: park at phase 0 and take any pending step right away
        acc_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
        apply        = 1'b1;
      end else if (sync_c) begin
        acc_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        tick_d[i]    = 1'b0;
        apply        = 1'b1;
      end else begin
        acc_d[i]     = sum[ACC_W-1:0];
        tick_d[i]    = sum[ACC_W];
        clk_out_d[i] = acc_q[i][ACC_W-1];
        apply        = sum[ACC_W];
      end
      // a write in the same cycle keeps the step pending for the next opportunity
      if (apply && pend_valid_q[i] && !wr_hit) begin
        step_d[i]       = pend_q[i];
        pend_valid_d[i] = 1'b0;
      end
      if (wr_hit) begin
        pend_d[i]       = wr_data;
        pend_valid_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CH); i++) begin
        acc_q[i]  <= '0;
        step_q[i] <= ACC_W'(DEFAULT_STEP);
        pend_q[i] <= '0;
      end
      pend_valid_q <= '0;
      clk_out_q    <= '0;
      tick_q       <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        acc_q[i]  <= acc_d[i];
        step_q[i] <= step_d[i];
        pend_q[i] <= pend_d[i];
      end
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

endmodule

// File: tb/tb_nco_multi_clk.sv
// Self-checking bench for nco_multi_clk: cycle-level reference model plus directed checks.
module tb_nco_multi_clk;

  localparam int unsigned     CH       = 2;
  localparam int unsigned     AW       = 2;
  localparam int unsigned     ACC_W    = 32;
  localparam longint unsigned MOD      = 64'h1_0000_0000;
  localparam longint unsigned DEF_STEP = 64'd158329674;

  logic             clk_50m = 1'b0;
  logic             rst     = 1'b1;
  logic [CH-1:0]    ch_en   = '0;
  logic             wr_en   = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [ACC_W-1:0] wr_data = '0;
  logic [CH-1:0]    step_pending;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
`ifdef NCO_SYNC_EN
  logic             sync_in = 1'b0;
`endif

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;

  nco_multi_clk #(.CH(CH), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .ch_en        (ch_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .step_pending (step_pending),
    .clk_out      (clk_out),
    .tick         (tick)
`ifdef NCO_SYNC_EN
    ,
    .sync_in      (sync_in)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input longint unsigned got, input longint unsigned want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input longint unsigned got,
                             input longint unsigned lo, input longint unsigned hi);
    n_chk++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Reference model: phase as an integer modulo 2**32, steps as plain numbers
  longint unsigned m_acc [CH];
  longint unsigned m_step[CH];
  longint unsigned m_pend[CH];
  bit              m_pv  [CH];
  bit              m_tick[CH];
  bit              m_clk [CH];

  always @(posedge clk_50m or posedge rst) begin
    longint unsigned nxt;
    bit hit, wrapped, syn;
    if (rst) begin
      for (int i = 0; i < int'(CH); i++) begin
        m_acc[i] = 0; m_step[i] = DEF_STEP; m_pend[i] = 0;
        m_pv[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
      end
    end else begin
`ifdef NCO_SYNC_EN
      syn = sync_in;
`else
      syn = 1'b0;
`endif
      for (int i = 0; i < int'(CH); i++) begin
        hit     = wr_en && (int'(wr_addr) == i);
        wrapped = 1'b0;
        if (!ch_en[i] || syn) begin
          m_acc[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        end else begin
          m_clk[i]  = (m_acc[i] >= MOD / 2);
          nxt       = m_acc[i] + m_step[i];
          wrapped   = (nxt >= MOD);
          m_tick[i] = wrapped;
          m_acc[i]  = nxt % MOD;
        end
        if ((!ch_en[i] || syn || wrapped) && m_pv[i] && !hit) begin
          m_step[i] = m_pend[i];
          m_pv[i]   = 1'b0;
        end
        if (hit) begin
          m_pend[i] = longint'(wr_data);
          m_pv[i]   = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_50m) begin
    if (chk_on) begin
      check("cycle tick", longint'(tick), longint'({m_tick[1], m_tick[0]}));
      check("cycle clk_out", longint'(clk_out), longint'({m_clk[1], m_clk[0]}));
      check("cycle step_pending", longint'(step_pending), longint'({m_pv[1], m_pv[0]}));
    end
  end

  initial begin
    int  cnt0, cnt1, ones, k;
    bit  found, prev;

    // reset, then a pending write, then asynchronous reset between edges
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk_50m);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'(DEF_STEP);
    @(negedge clk_50m);
    wr_en = 1'b0;
    check("pending before reset", longint'(step_pending), 2);
    #3 rst = 1'b1;
    #1;
    check("async reset tick", longint'(tick), 0);
    check("async reset clk_out", longint'(clk_out), 0);
    check("async reset step_pending", longint'(step_pending), 0);
    @(negedge clk_50m);
    rst = 1'b0;

    // default rate on ch0 over 20000 cycles: 20000*158329674/2**32 = 737.28
    @(negedge clk_50m);
    ch_en = 2'b01;
    cnt0 = 0; cnt1 = 0;
    repeat (20000) begin
      @(negedge clk_50m);
      cnt0 += int'(tick[0]);
      cnt1 += int'(tick[1]);
    end
    check_range("default rate ch0 ticks", longint'(cnt0), 736, 738);
    check("idle ch1 ticks", longint'(cnt1), 0);

    // step change to half-scale, applied at the next wrap
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h8000_0000;
    @(negedge clk_50m);
    wr_en = 1'b0;
    check("step change pending", longint'(step_pending[0]), 1);
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_50m);
      if (!step_pending[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("step change applied", longint'(found), 1);
    check("tick at apply", longint'(tick[0]), 1);
    prev = clk_out[0];
    cnt0 = 0;
    repeat (8) begin
      @(negedge clk_50m);
      check("half-scale toggle", longint'(clk_out[0]), longint'(!prev));
      prev = clk_out[0];
      cnt0 += int'(tick[0]);
    end
    check("half-scale ticks in 8", longint'(cnt0), 4);

    // out-of-range addresses are ignored
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 32'h0;
    @(negedge clk_50m);
    wr_addr = 2'd2;
    @(negedge clk_50m);
    wr_en = 1'b0;
    check("bad address no pending", longint'(step_pending), 0);

    // write to ch1 in the exact cycle it wraps
    ch_en = 2'b11;
    found = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk_50m);
      if (m_acc[1] + m_step[1] >= MOD) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h4000_0000;
        found = 1'b1;
        break;
      end
    end
    check("collision slot found", longint'(found), 1);
    @(negedge clk_50m);
    wr_en = 1'b0;
    check("collision tick", longint'(tick[1]), 1);
    check("collision still pending", longint'(step_pending[1]), 1);
    k = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_50m);
      if (tick[1]) begin
        k = j;
        break;
      end
    end
    check_range("collision old-step gap", longint'(k), 27, 28);
    check("collision applied next wrap", longint'(step_pending[1]), 0);
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk_50m);
      if (tick[1]) begin
        k = j;
        break;
      end
    end
    check("collision new-step gap", longint'(k), 4);

    // disable ch0 for 5 cycles, load quarter-scale step meanwhile
    ch_en = 2'b10;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h4000_0000;
    repeat (5) begin
      @(negedge clk_50m);
      wr_en = 1'b0;
      check("disabled clk_out", longint'(clk_out[0]), 0);
      check("disabled tick", longint'(tick[0]), 0);
    end
    ch_en = 2'b11;
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk_50m);
      if (tick[0]) begin
        k = j;
        break;
      end
    end
    check("first tick after enable", longint'(k), 4);

    // zero step: no ticks and a low output for 1000 cycles
    ch_en = 2'b10;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h0;
    repeat (3) begin
      @(negedge clk_50m);
      wr_en = 1'b0;
    end
    ch_en = 2'b11;
    cnt0 = 0; ones = 0;
    repeat (1000) begin
      @(negedge clk_50m);
      cnt0 += int'(tick[0]);
      ones += int'(clk_out[0]);
    end
    check("zero step ticks", longint'(cnt0), 0);
    check("zero step clk_out", longint'(ones), 0);

`ifdef NCO_SYNC_EN
    // sync pulse aligns both channels and applies pending steps
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h2000_0000;
    @(negedge clk_50m);
    wr_en = 1'b0;
    sync_in = 1'b1;
    @(negedge clk_50m);
    sync_in = 1'b0;
    check("sync tick", longint'(tick), 0);
    check("sync clk_out", longint'(clk_out), 0);
    check("sync pending cleared", longint'(step_pending), 0);
    repeat (50) @(negedge clk_50m);
`endif

    chk_on = 1'b0;
    @(negedge clk_50m);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
